ps2_scancode_sequencer: RTL and testbench

- Controller that sequences PS/2 keyboard reception on the system clock.
- Oversamples the raw PS/2 clock and data lines, frames and checks each 11-bit packet, then runs the scancode prefix state machine (E0 extended, F0 release).
- Buffers decoded key events in a small FIFO with a valid/ready handshake toward the game/application logic.

---
 rtl/ps2_scancode_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ps2_scancode_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_sequencer.sv
// PS/2 keyboard receiver: synchronises the raw lines, frames 11-bit packets,
// strips E0/F0 prefixes and queues key events behind a valid/ready FIFO.
module ps2_scancode_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_extended,
  output logic       evt_release,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned EVT_W = 10;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_e;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_REL, D_EXT_REL} dec_state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   prev_clk_q, prev_clk_d;
  frame_state_e           fstate_q, fstate_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   byte_done_q, byte_done_d;
  dec_state_e             dstate_q, dstate_d;
  logic                   push_q, push_d;
  logic [EVT_W-1:0]       ev_q, ev_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ovf_q, ovf_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [EVT_W-1:0]       mem_q [FIFO_DEPTH];
  logic                   clk_s, data_s, fall, ferr, derr, pop, wr_en;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall = prev_clk_q & ~clk_s;

  // Frame FSM: start/data/parity/stop with inter-edge timeout
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    prev_clk_d  = clk_s;
    fstate_d    = fstate_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tmo_d       = tmo_q;
    byte_done_d = 1'b0;
    ferr        = 1'b0;
    if (fall) begin
      tmo_d = '0;
    end else if (fstate_q != F_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    if (fstate_q != F_IDLE && !fall && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      fstate_d = F_IDLE;
      tmo_d    = '0;
      ferr     = 1'b1;
    end else if (fall) begin
      case (fstate_q)
        F_IDLE: if (!data_s) begin
          fstate_d  = F_DATA;
          bit_cnt_d = '0;
        end
        F_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) fstate_d = F_PARITY;
        end
        F_PARITY: begin
          par_ok_d = ^{shift_q, data_s};
          fstate_d = F_STOP;
        end
        default: begin
          if (par_ok_q && data_s) byte_done_d = 1'b1;
          else                    ferr = 1'b1;
          fstate_d = F_IDLE;
        end
      endcase
    end
  end

  // Prefix decoder: E0 marks extended, F0 marks release
  always_comb begin
    dstate_d = dstate_q;
    push_d   = 1'b0;
    ev_d     = ev_q;
    derr     = 1'b0;
    if (ferr) begin
      dstate_d = D_BASE;
    end else if (byte_done_q) begin
      case (dstate_q)
        D_BASE: begin
          if (shift_q == 8'hE0)      dstate_d = D_EXT;
          else if (shift_q == 8'hF0) dstate_d = D_REL;
          else begin push_d = 1'b1; ev_d = {shift_q, 2'b00}; end
        end
        D_EXT: begin
          if (shift_q == 8'hF0)      dstate_d = D_EXT_REL;
          else if (shift_q == 8'hE0) derr = 1'b1;
          else begin push_d = 1'b1; ev_d = {shift_q, 2'b10}; dstate_d = D_BASE; end
        end
        default: begin
          dstate_d = D_BASE;
          if (shift_q == 8'hE0 || shift_q == 8'hF0) derr = 1'b1;
          else begin
            push_d = 1'b1;
            ev_d   = {shift_q, (dstate_q == D_EXT_REL), 1'b1};
          end
        end
      endcase
    end
    frame_err_d = ferr | derr;
  end

  // Event FIFO; a push into a full FIFO only succeeds if the head pops
  always_comb begin
    pop      = (count_q != '0) && evt_ready;
    wr_en    = push_q && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    ovf_d    = ovf_q | (push_q & ~wr_en);
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_clk_q  <= 1'b1;
      fstate_q    <= F_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      byte_done_q <= 1'b0;
      dstate_q    <= D_BASE;
      push_q      <= 1'b0;
      ev_q        <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      prev_clk_q  <= prev_clk_d;
      fstate_q    <= fstate_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      byte_done_q <= byte_done_d;
      dstate_q    <= dstate_d;
      push_q      <= push_d;
      ev_q        <= ev_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ev_q;
  end

  // Head fields read as zero while the FIFO is empty
  assign evt_valid    = (count_q != '0);
  assign evt_code     = evt_valid ? mem_q[rd_ptr_q][9:2] : 8'h00;
  assign evt_extended = evt_valid & mem_q[rd_ptr_q][1];
  assign evt_release  = evt_valid & mem_q[rd_ptr_q][0];
  assign frame_err    = frame_err_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench for ps2_scancode_sequencer: stimulus pushes expected key events
// into a queue, a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_ps2_scancode_sequencer;

  localparam int HALF = 40;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data, evt_ready;
  logic       evt_valid, evt_extended, evt_release, frame_err, overflow;
  logic [7:0] evt_code;

  typedef struct packed {logic [7:0] code; logic ext; logic rel;} ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int exp_err = 0;
  int valid_cycles = 0;

  ps2_scancode_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_extended(evt_extended), .evt_release(evt_release),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops on handshake, error pulses and valid cycles counted
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (evt_valid) valid_cycles++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL evt_unexpected: got code=%0h ext=%0b rel=%0b want none",
                   evt_code, evt_extended, evt_release);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("evt_fields", 32'({evt_code, evt_extended, evt_release}), 32'(e));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(10);
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic x, input logic r);
    ev_t e;
    e.code = c; e.ext = x; e.rel = r;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    wait_clk(5);
    check("reset_outputs", 32'({evt_valid, evt_code, evt_extended, evt_release, frame_err, overflow}), 32'h0);
    reset = 1'b0;
    wait_clk(5);

    // Single make code, consumer always ready
    evt_ready = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_no_err", 32'(err_seen), 32'(exp_err));
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Extended release, held until ready
    evt_ready = 1'b0;
    expect_ev(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    wait_clk(20);
    check("t2_held_valid", 32'(evt_valid), 32'd1);
    check("t2_head", 32'({evt_code, evt_extended, evt_release}), 32'({8'h75, 1'b1, 1'b1}));
    check("t2_not_popped", 32'(exp_q.size()), 32'd1);
    evt_ready = 1'b1;
    wait_clk(1);
    check("t2_valid_drop", 32'(evt_valid), 32'd0);

    // Parity error, then a clean release sequence
    send_frame(8'h1C, 1'b1);
    exp_err++;
    check("t3_parity_err", 32'(err_seen), 32'(exp_err));
    check("t3_no_event", 32'(evt_valid), 32'd0);
    expect_ev(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("t3_release", 32'(exp_q.size()), 32'd0);

    // Clock stops mid-frame: timeout, then a clean frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(TMO + 100);
    exp_err++;
    check("t4_timeout_err", 32'(err_seen), 32'(exp_err));
    expect_ev(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0);
    check("t4_after_timeout", 32'(exp_q.size()), 32'd0);

    // Overflow: five makes into a four-deep FIFO
    evt_ready = 1'b0;
    expect_ev(8'h16, 1'b0, 1'b0);
    expect_ev(8'h1E, 1'b0, 1'b0);
    expect_ev(8'h26, 1'b0, 1'b0);
    expect_ev(8'h25, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h26, 1'b0);
    send_frame(8'h25, 1'b0);
    check("t5_no_ovf_yet", 32'(overflow), 32'd0);
    send_frame(8'h2E, 1'b0);
    check("t5_overflow", 32'(overflow), 32'd1);
    check("t5_head", 32'(evt_code), 32'h16);
    evt_ready = 1'b1;
    wait_clk(20);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_empty", 32'(evt_valid), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame after five bits
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    reset = 1'b1;
    wait_clk(3);
    check("t6_reset_outputs", 32'({evt_valid, evt_code, evt_extended, evt_release, frame_err, overflow}), 32'h0);
    reset = 1'b0;
    wait_clk(5);
    expect_ev(8'h3A, 1'b0, 1'b0);
    send_frame(8'h3A, 1'b0);
    wait_clk(10);
    check("t6_no_err", 32'(err_seen), 32'(exp_err));
    check("t6_event", 32'(exp_q.size()), 32'd0);
    check("final_err_count", 32'(err_seen), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
